// File: rtl/state_lookup_pipe.sv
// state_lookup_pipe: two-stage ternary flow-key lookup with action rewrite.
// Ports: clk/reset; match_* request in, action/src_port/out_* result out
// (ready/valid); cfg_* table write; table_flush; cnt_rd_* hit counter read.
`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 96
`endif
`ifndef OPENFLOW_SET_NW_SRC_POS
`define OPENFLOW_SET_NW_SRC_POS 16
`endif
`ifndef OPENFLOW_SET_NW_DST_POS
`define OPENFLOW_SET_NW_DST_POS 48
`endif
`ifndef OPENFLOW_NF2_ACTION_FLAG_POS
`define OPENFLOW_NF2_ACTION_FLAG_POS 0
`endif
`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 8
`endif

module state_lookup_pipe #(
    parameter int ST_WIDTH       = 64,
    parameter int ST_SIZE        = 8,
    parameter int ST_SIZE_BITS   = $clog2(ST_SIZE),
    parameter int ADDR_WIDTH     = 32,
    parameter int ACTION_WIDTH   = `OPENFLOW_ACTION_WIDTH,
    parameter int SRC_POS        = `OPENFLOW_SET_NW_SRC_POS,
    parameter int DST_POS        = `OPENFLOW_SET_NW_DST_POS,
    parameter int FLAG_POS       = `OPENFLOW_NF2_ACTION_FLAG_POS,
    parameter int SRC_PORT_WIDTH = `OPENFLOW_ENTRY_SRC_PORT_WIDTH,
    parameter int CNT_WIDTH      = 32,
    parameter bit MISS_DROP_FLAG = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ST_WIDTH-1:0]       match_field,
    input  logic                      match_vld,
    output logic                      match_rdy,
    input  logic [ACTION_WIDTH-1:0]   action_in,
    input  logic [SRC_PORT_WIDTH-1:0] src_port_in,
    output logic [ACTION_WIDTH-1:0]   action_out,
    output logic [SRC_PORT_WIDTH-1:0] src_port_out,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      out_hit,
    output logic [ST_SIZE_BITS-1:0]   out_hit_addr,
    input  logic                      cfg_we,
    input  logic [ST_SIZE_BITS-1:0]   cfg_addr,
    input  logic [ST_WIDTH-1:0]       cfg_key,
    input  logic [ST_WIDTH-1:0]       cfg_mask,
    input  logic [2*ADDR_WIDTH+1:0]   cfg_data,
    input  logic                      cfg_entry_vld,
    input  logic [ST_SIZE_BITS-1:0]   cnt_rd_addr,
    output logic [CNT_WIDTH-1:0]      cnt_rd_data,
    input  logic                      table_flush
);
    localparam int DW = 2*ADDR_WIDTH+2;

    logic [ST_SIZE-1:0]   vld_q;
    logic [ST_WIDTH-1:0]  key_q  [ST_SIZE];
    logic [ST_WIDTH-1:0]  mask_q [ST_SIZE];
    logic [DW-1:0]        data_q [ST_SIZE];
    logic [CNT_WIDTH-1:0] cnt_q  [ST_SIZE];

    logic                      s1_vld_q;
    logic                      s1_hit_q;
    logic [ST_SIZE_BITS-1:0]   s1_idx_q;
    logic [DW-1:0]             s1_data_q;
    logic [ACTION_WIDTH-1:0]   s1_act_q;
    logic [SRC_PORT_WIDTH-1:0] s1_port_q;

    logic                      adv;
    logic                      accept;
    logic                      hit_d;
    logic [ST_SIZE_BITS-1:0]   idx_d;
    logic [ACTION_WIDTH-1:0]   act_d;

    assign adv       = !out_vld || out_rdy;
    assign match_rdy = adv;
    assign accept    = match_vld && adv;

    // Scan high to low so the lowest matching index is the last to win.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int i = ST_SIZE-1; i >= 0; i--) begin
            if (vld_q[i] &&
                (((match_field ^ key_q[i]) & ~mask_q[i]) == '0)) begin
                hit_d = 1'b1;
                idx_d = ST_SIZE_BITS'(i);
            end
        end
    end

    // Flush beats write, write beats the hit increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < ST_SIZE; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < ST_SIZE; i++) begin
                if (table_flush) begin
                    vld_q[i] <= 1'b0;
                    cnt_q[i] <= '0;
                end else if (cfg_we && cfg_addr == ST_SIZE_BITS'(i)) begin
                    vld_q[i] <= cfg_entry_vld;
                    cnt_q[i] <= '0;
                end else if (accept && hit_d &&
                             idx_d == ST_SIZE_BITS'(i) &&
                             cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && !table_flush) begin
            key_q[cfg_addr]  <= cfg_key;
            mask_q[cfg_addr] <= cfg_mask;
            data_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_data_q <= '0;
            s1_act_q  <= '0;
            s1_port_q <= '0;
        end else if (adv) begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_hit_q  <= hit_d;
                s1_idx_q  <= idx_d;
                s1_data_q <= data_q[idx_d];
                s1_act_q  <= action_in;
                s1_port_q <= src_port_in;
            end
        end
    end

    // data layout: {mod_dst_en, mod_src_en, new_dst, new_src}
    always_comb begin
        act_d = s1_act_q;
        if (s1_hit_q) begin
            if (s1_data_q[DW-2])
                act_d[SRC_POS +: ADDR_WIDTH] = s1_data_q[ADDR_WIDTH-1:0];
            if (s1_data_q[DW-1])
                act_d[DST_POS +: ADDR_WIDTH] =
                    s1_data_q[2*ADDR_WIDTH-1:ADDR_WIDTH];
            act_d[FLAG_POS +: 16] = s1_act_q[FLAG_POS +: 16] |
                {8'h00, s1_data_q[DW-1], s1_data_q[DW-2], 6'h00};
        end else if (MISS_DROP_FLAG) begin
            act_d[FLAG_POS+15] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld      <= 1'b0;
            out_hit      <= 1'b0;
            out_hit_addr <= '0;
            action_out   <= '0;
            src_port_out <= '0;
        end else if (adv) begin
            out_vld <= s1_vld_q;
            if (s1_vld_q) begin
                out_hit      <= s1_hit_q;
                out_hit_addr <= s1_hit_q ? s1_idx_q : '0;
                action_out   <= act_d;
                src_port_out <= s1_port_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_rd_data <= '0;
        else        cnt_rd_data <= cnt_q[cnt_rd_addr];
    end

endmodule
